// File: rtl/jam_cost_table.sv
// rtl/jam_cost_table.sv - 8x8 cost-matrix store feeding the JAM assignment engine
//
// Loads a 2^IDX_W x 2^IDX_W cost table from a valid/ready stream in row-major
// (worker-major) order. It answers (W, J) lookups combinationally and holds JAM
// in reset until a complete table is present.
//
// Optional feature: define JAM_COST_TABLE_PARITY_EN to enable even-parity
// checking of the incoming entries. A load that contains any bad entry ends in
// IDLE instead of READY.
//
// Ports:
//   CLK          clock, all state on rising edge
//   RST          asynchronous, active-high reset
//   load_start   single-cycle request to (re)load the table
//   in_valid     upstream data valid
//   in_ready     table accepting data (state LOAD)
//   in_data      cost entry, row-major order
//   in_par       even-parity bit over in_data (parity build only)
//   W, J         worker / job lookup index from JAM
//   Cost         table[W][J] in READY, 0 otherwise
//   table_ready  complete, valid table held
//   jam_rst      registered reset to JAM, high until table valid
//   load_err     one-cycle pulse: load_start seen while loading
//   par_err      sticky parity failure flag (tied 0 without parity build)

module jam_cost_table #(
    parameter int COST_W = 7,
    parameter int IDX_W  = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load_start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COST_W-1:0] in_data,
    input  logic              in_par,
    input  logic [IDX_W-1:0]  W,
    input  logic [IDX_W-1:0]  J,
    output logic [COST_W-1:0] Cost,
    output logic              table_ready,
    output logic              jam_rst,
    output logic              load_err,
    output logic              par_err
);

    localparam int AW    = 2 * IDX_W;
    localparam int N_ENT = 1 << AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [COST_W-1:0] tbl_q [N_ENT];
    logic              jam_rst_q;
    logic              load_err_q;
    logic              par_err_q, par_err_d;

    logic              accept;
    logic              restart;
    logic              bad_par;

`ifdef JAM_COST_TABLE_PARITY_EN
    assign bad_par = ^{in_data, in_par};
`else
    logic unused_par;
    assign unused_par = in_par;
    assign bad_par    = 1'b0;
`endif

    // A load_start while loading takes priority and swallows the same-cycle beat.
    assign restart = (state_q == LOAD) && load_start;
    assign accept  = (state_q == LOAD) && in_valid && !load_start;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        par_err_d = par_err_q;
        case (state_q)
            IDLE, READY: begin
                if (load_start) begin
                    state_d   = LOAD;
                    idx_d     = '0;
                    par_err_d = 1'b0;
                end
            end
            LOAD: begin
                if (restart) begin
                    idx_d = '0;
                end else if (accept) begin
                    idx_d = idx_q + 1'b1;
                    if (bad_par) begin
                        par_err_d = 1'b1;
                    end
                    // Last entry: the index never wraps because LOAD is left here.
                    if (idx_q == {AW{1'b1}}) begin
                        state_d = (par_err_q || bad_par) ? IDLE : READY;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            jam_rst_q  <= 1'b1;
            load_err_q <= 1'b0;
            par_err_q  <= 1'b0;
            for (int i = 0; i < N_ENT; i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            // Registered from the next state so JAM's reset edge lines up with
            // the state entering or leaving READY.
            jam_rst_q  <= (state_d != READY);
            load_err_q <= restart;
            par_err_q  <= par_err_d;
            if (accept) begin
                tbl_q[idx_q] <= in_data;
            end
        end
    end

    assign in_ready    = (state_q == LOAD);
    assign table_ready = (state_q == READY);
    assign Cost        = (state_q == READY) ? tbl_q[{W, J}] : '0;
    assign jam_rst     = jam_rst_q;
    assign load_err    = load_err_q;

`ifdef JAM_COST_TABLE_PARITY_EN
    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_jam_cost_table.sv
// tb/tb_jam_cost_table.sv - directed scoreboard bench for jam_cost_table

module tb_jam_cost_table;

    logic       CLK;
    logic       RST;
    logic       load_start;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_data;
    logic       in_par;
    logic [2:0] W;
    logic [2:0] J;
    logic [6:0] Cost;
    logic       table_ready;
    logic       jam_rst;
    logic       load_err;
    logic       par_err;

    int vectors     = 0;
    int miscompares = 0;

    int        model [64];
    int        exp_q [$];
    int        rc;
    int        cyc;
    bit        par_on;

    jam_cost_table #(.COST_W(7), .IDX_W(3)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .load_start  (load_start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_par      (in_par),
        .W           (W),
        .J           (J),
        .Cost        (Cost),
        .table_ready (table_ready),
        .jam_rst     (jam_rst),
        .load_err    (load_err),
        .par_err     (par_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issues load_start, then streams entries (idx + base) % 100 until stop_at
    // accepts. Called at posedge+1; returns at posedge+1.
    task automatic do_load(input int base, input bit toggle, input int stop_at,
                           input int bad_idx, input bit exp_ready, input bit exp_lerr,
                           output int ready_cycles, output int cycles);
        int  idx;
        int  early;
        bit  acc;
        logic [6:0] d;
        load_start = 1'b1;
        @(posedge CLK); #1;
        load_start = 1'b0;
        in_valid   = 1'b0;
        check("start_in_ready", in_ready, 1);
        check("start_table_ready", table_ready, 0);
        check("start_jam_rst", jam_rst, 1);
        check("start_cost_gated", Cost, 0);
        check("start_load_err", load_err, exp_lerr);
        idx = 0; cycles = 0; ready_cycles = 0; early = 0;
        while (idx < stop_at && cycles < 400) begin
            d        = 7'((idx + base) % 100);
            in_data  = d;
            in_par   = (idx == bad_idx) ? ~(^d) : ^d;
            in_valid = toggle ? (cycles % 2 == 0) : 1'b1;
            if (cycles == 1) check("load_err_one_cycle", load_err, 0);
            if (in_ready) ready_cycles++;
            if (table_ready) early++;
            acc = in_valid & in_ready;
            @(posedge CLK); #1;
            if (acc) begin
                model[idx] = int'(d);
                idx++;
            end
            cycles++;
        end
        in_valid = 1'b0;
        check("accepts", idx, stop_at);
        if (stop_at == 64) begin
            check("no_early_ready", early, 0);
            check("end_table_ready", table_ready, exp_ready);
            check("end_jam_rst", jam_rst, !exp_ready);
            check("end_in_ready", in_ready, 0);
        end
    endtask

    task automatic readback(input bit ready);
        for (int i = 0; i < 64; i++) begin
            W = 3'(i >> 3);
            J = 3'(i & 7);
            exp_q.push_back(ready ? model[i] : 0);
            #1;
            check($sformatf("cost_w%0d_j%0d", i >> 3, i & 7), Cost, exp_q.pop_front());
        end
        @(posedge CLK); #1;
    endtask

    initial begin
`ifdef JAM_COST_TABLE_PARITY_EN
        par_on = 1'b1;
`else
        par_on = 1'b0;
`endif
        RST = 1'b1; load_start = 1'b0; in_valid = 1'b0;
        in_data = '0; in_par = 1'b0; W = 3'd3; J = 3'd5;
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_table_ready", table_ready, 0);
        check("rst_jam_rst", jam_rst, 1);
        check("rst_cost", Cost, 0);
        check("rst_load_err", load_err, 0);
        check("rst_par_err", par_err, 0);
        #11 RST = 1'b0;
        @(posedge CLK); #1;
        check("idle_in_ready", in_ready, 0);

        // Full load with in_valid held high, data = index mod 100.
        do_load(0, 1'b0, 64, -1, 1'b1, 1'b0, rc, cyc);
        check("held_in_ready_cycles", rc, 64);
        W = 3'd3; J = 3'd5;
        exp_q.push_back(29);
        #1;
        check("cost_w3_j5", Cost, exp_q.pop_front());
        readback(1'b1);

        // Reload from READY with in_valid toggling; first accept on cycle 0,
        // 64th on cycle 126, so in_ready is high for 127 cycles.
        do_load(7, 1'b1, 64, -1, 1'b1, 1'b0, rc, cyc);
        check("toggle_in_ready_cycles", rc, 127);
        readback(1'b1);

        // Restart at index 20 with a same-cycle beat that must be dropped.
        do_load(11, 1'b0, 20, -1, 1'b0, 1'b0, rc, cyc);
        in_valid = 1'b1; in_data = 7'd99; in_par = ^7'd99;
        do_load(50, 1'b0, 64, -1, 1'b1, 1'b1, rc, cyc);
        check("restart_in_ready_cycles", rc, 64);
        readback(1'b1);

        // Asynchronous reset at index 40.
        do_load(3, 1'b0, 40, -1, 1'b0, 1'b0, rc, cyc);
        #2 RST = 1'b1;
        #1;
        check("arst_in_ready", in_ready, 0);
        check("arst_jam_rst", jam_rst, 1);
        check("arst_table_ready", table_ready, 0);
        #1 RST = 1'b0;
        @(posedge CLK); #1;
        for (int i = 0; i < 64; i += 9) begin
            W = 3'(i >> 3); J = 3'(i & 7);
            exp_q.push_back(0);
            #1;
            check("arst_idle_cost", Cost, exp_q.pop_front());
        end
        @(posedge CLK); #1;
        check("arst_idle_in_ready", in_ready, 0);

        // Bad parity on entry 10.
        do_load(0, 1'b0, 64, 10, !par_on, 1'b0, rc, cyc);
        check("parity_par_err", par_err, par_on);
        readback(!par_on);

        // A clean load clears the sticky flag.
        do_load(21, 1'b0, 64, -1, 1'b1, 1'b0, rc, cyc);
        check("clean_par_err", par_err, 0);
        readback(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/jam_cost_table.md
# jam_cost_table

Cost-matrix store that sits directly upstream of the JAM job-assignment engine. It accepts the 8×8 worker/job cost matrix as a 64-entry valid/ready stream and holds it in a register file. It answers JAM's (W, J) lookups with a same-cycle combinational Cost, and holds JAM in reset until a complete table is present.

## Interface
Parameters:
- COST_W, 7, width of one cost entry (matches JAM Cost port)
- IDX_W, 3, width of worker/job index; table is 2^IDX_W × 2^IDX_W entries

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- load_start  in  1  single-cycle request to (re)load the table
- in_valid  in  1  upstream data valid
- in_ready  out  1  table accepting data
- in_data  in  COST_W  cost entry, row-major (worker-major) order
- in_par  in  1  even-parity bit over in_data (used only with parity macro)
- W  in  IDX_W  worker index from JAM
- J  in  IDX_W  job index from JAM
- Cost  out  COST_W  table[W][J]
- table_ready  out  1  complete, valid table held
- jam_rst  out  1  reset to JAM, high until table valid
- load_err  out  1  one-cycle pulse: load_start seen while loading
- par_err  out  1  sticky parity failure flag

## Operation
- States: IDLE (no valid table), LOAD, READY.
- Reset: state IDLE, all 64 entries 0, write index 0, in_ready 0, Cost 0, table_ready 0, jam_rst 1, load_err 0, par_err 0.
- IDLE: load_start → LOAD with index 0; otherwise stay.
- LOAD: in_ready = 1. Accept = in_valid & in_ready. Each accept writes in_data to entry {index}, where worker = index[5:3] and job = index[2:0], then increments index. Accept of index 63 → READY (or IDLE under parity failure, see Configuration).
- load_start in LOAD: restarts the load at index 0, discards any same-cycle accept, and pulses load_err for one cycle. Entries already written remain stale until overwritten.
- READY: table_ready = 1. load_start → LOAD at index 0, so table_ready and jam_rst change on that edge. A reload therefore resets JAM.
- Cost = table[{W,J}] combinationally in READY, and 0 in IDLE/LOAD.
- Index counter is 6 bits. It never wraps inside LOAD, because index 63 exits.
- load_start and in_valid in IDLE/READY: in_valid is ignored (in_ready = 0). load_start is honored.

## Timing
- in_ready, table_ready and Cost-gating decode directly from the state register. No extra latency.
- jam_rst is registered: jam_rst <= (next_state != READY). It falls on the same edge that state enters READY, and rises on the same edge that state leaves READY.
- Cost read path is zero-latency: it is valid in the same cycle that W/J change, so JAM samples it at its next edge.
- Last accept to table_ready high: 1 edge.
- load_start to in_ready high: 1 edge.
- load_err: high exactly one cycle after the offending edge.
- Async RST mid-load: all state and entries return to reset values immediately, and jam_rst goes to 1.

## Configuration
- Macro: JAM_COST_TABLE_PARITY_EN.
- Defined:
  - On each accept, check ^{in_data, in_par} == 0. On mismatch, write the entry anyway and set par_err (sticky until RST or next load_start from IDLE/READY).
  - At the index-63 accept, if par_err is set, go to IDLE instead of READY. table_ready stays 0 and jam_rst stays 1.
- Undefined: in_par is ignored, par_err is tied 0, and the index-63 accept always goes to READY.

## Test plan
- Reset, then load_start, then 64 entries with in_valid held high, data = index mod 100. Required response:
  - in_ready is high for exactly 64 cycles.
  - table_ready and jam_rst change on the 64th accept edge.
  - W=3, J=5 gives Cost = 29.
- Load with in_valid toggling every other cycle. Required: 64 accepts spread over 128 cycles, and every (W,J) readback matches the row-major data.
- load_start at index 20 of a load. Required: load_err pulses for one cycle, the index returns to 0, and exactly 64 further accepts are needed to reach READY.
- In READY, pulse load_start. Required:
  - Next cycle: jam_rst = 1, table_ready = 0, Cost = 0.
  - After the reload: new values are returned.
- Assert RST at index 40. Required: immediately in_ready = 0, jam_rst = 1, and all entries read 0 after a fresh full load of zeros is skipped (check via Cost = 0 after RST while in IDLE).
- Parity: with JAM_COST_TABLE_PARITY_EN defined, a bad in_par on entry 10 sets par_err; after entry 63 the state is IDLE and table_ready = 0. With the macro undefined, the same stimulus reaches READY with par_err = 0.
